// File: rtl/jelly_video_frame_generator.sv
// AXI4-Stream video frame source: whole frames, tuser[0] on the first pixel, tlast at each line end.
// Optional build macro JELLY_VIDEO_FRAME_GENERATOR_FCNT_EN adds a frame counter folded into tdata.
module jelly_video_frame_generator #(
  parameter int TUSER_WIDTH = 1,
  parameter int TDATA_WIDTH = 24,
  parameter int X_WIDTH     = 12,
  parameter int Y_WIDTH     = 12,
  parameter int FCNT_WIDTH  = 8
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   aclken,
  input  logic                   enable,
  output logic                   busy,
  input  logic [X_WIDTH-1:0]     param_width,
  input  logic [Y_WIDTH-1:0]     param_height,
  output logic [TUSER_WIDTH-1:0] m_axi4s_tuser,
  output logic                   m_axi4s_tlast,
  output logic [TDATA_WIDTH-1:0] m_axi4s_tdata,
  output logic                   m_axi4s_tvalid,
  input  logic                   m_axi4s_tready
);

  localparam int SUM_W = X_WIDTH + Y_WIDTH + TDATA_WIDTH + FCNT_WIDTH;

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t                   state_q;
  logic [X_WIDTH-1:0]       x_q, xl_q;
  logic [Y_WIDTH-1:0]       y_q, yl_q;
  logic                     tvalid_q, tuser_q, tlast_q, busy_q;
  logic [TDATA_WIDTH-1:0]   tdata_q;

  logic [X_WIDTH-1:0]       x_d, xl_d;
  logic [Y_WIDTH-1:0]       y_d, yl_d;
  logic                     tuser_d, tlast_d;
  logic [TDATA_WIDTH-1:0]   tdata_d;
  logic                     frame_end;
  logic                     advance;

  // A zero-sized dimension is treated as one; xl/yl hold the index of the last pixel/line.
  function automatic logic [X_WIDTH-1:0] last_x(input logic [X_WIDTH-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  function automatic logic [Y_WIDTH-1:0] last_y(input logic [Y_WIDTH-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

`ifdef JELLY_VIDEO_FRAME_GENERATOR_FCNT_EN
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;

  function automatic logic [TDATA_WIDTH-1:0] pixel(input logic [Y_WIDTH-1:0] y,
                                                   input logic [X_WIDTH-1:0] x,
                                                   input logic [FCNT_WIDTH-1:0] f);
    return TDATA_WIDTH'(SUM_W'({y, x}) + SUM_W'(f));
  endfunction
`else
  function automatic logic [TDATA_WIDTH-1:0] pixel(input logic [Y_WIDTH-1:0] y,
                                                   input logic [X_WIDTH-1:0] x);
    return TDATA_WIDTH'(SUM_W'({y, x}));
  endfunction
`endif

  assign advance   = aclken && (!tvalid_q || m_axi4s_tready);
  assign frame_end = (x_q == xl_q) && (y_q == yl_q);

  // Next beat to load: either the first beat of a fresh frame or the successor of the current one.
  always_comb begin
    x_d  = x_q + 1'b1;
    y_d  = y_q;
    xl_d = xl_q;
    yl_d = yl_q;
    if (state_q == ST_IDLE || frame_end) begin
      x_d  = '0;
      y_d  = '0;
      xl_d = last_x(param_width);
      yl_d = last_y(param_height);
    end else if (x_q == xl_q) begin
      x_d = '0;
      y_d = y_q + 1'b1;
    end
    tuser_d = (x_d == '0) && (y_d == '0);
    tlast_d = (x_d == xl_d);
`ifdef JELLY_VIDEO_FRAME_GENERATOR_FCNT_EN
    fcnt_d  = (state_q == ST_RUN && frame_end) ? fcnt_q + 1'b1 : fcnt_q;
    tdata_d = pixel(y_d, x_d, fcnt_d);
`else
    tdata_d = pixel(y_d, x_d);
`endif
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= ST_IDLE;
      x_q      <= '0;
      y_q      <= '0;
      xl_q     <= '0;
      yl_q     <= '0;
      tvalid_q <= 1'b0;
      tuser_q  <= 1'b0;
      tlast_q  <= 1'b0;
      tdata_q  <= '0;
      busy_q   <= 1'b0;
`ifdef JELLY_VIDEO_FRAME_GENERATOR_FCNT_EN
      fcnt_q   <= '0;
`endif
    end else if (advance) begin
      case (state_q)
        ST_IDLE: begin
          if (enable) begin
            state_q  <= ST_RUN;
            x_q      <= x_d;
            y_q      <= y_d;
            xl_q     <= xl_d;
            yl_q     <= yl_d;
            tvalid_q <= 1'b1;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
            busy_q   <= 1'b1;
          end
        end
        ST_RUN: begin
`ifdef JELLY_VIDEO_FRAME_GENERATOR_FCNT_EN
          fcnt_q <= fcnt_d;
`endif
          // enable only matters once the final beat of the frame has been accepted
          if (frame_end && !enable) begin
            state_q  <= ST_IDLE;
            tvalid_q <= 1'b0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            x_q      <= x_d;
            y_q      <= y_d;
            xl_q     <= xl_d;
            yl_q     <= yl_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            tdata_q  <= tdata_d;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy           = busy_q;
  assign m_axi4s_tuser  = TUSER_WIDTH'(tuser_q);
  assign m_axi4s_tlast  = tlast_q;
  assign m_axi4s_tdata  = tdata_q;
  assign m_axi4s_tvalid = tvalid_q;

endmodule
